// File: rtl/mm_job_scheduler_pkg.sv
// Shared types for the matrix-multiply job scheduler: FSM states,
// completion codes and the packed job-word width.
package mm_job_scheduler_pkg;

  typedef enum logic [2:0] {
    SCH_IDLE,
    SCH_ISSUE,
    SCH_RUN,
    SCH_RELEASE,
    SCH_REPORT
  } sch_state_e;

  typedef enum logic [1:0] {
    DONE_OK      = 2'd0,
    DONE_ZERO    = 2'd1,
    DONE_TIMEOUT = 2'd2
  } done_err_e;

  // Job word layout, LSB first: m, k, n, addr_a, addr_b, addr_p, id.
  function automatic int unsigned job_width(input int unsigned aw, input int unsigned idw);
    return 6 * aw + idw;
  endfunction

endpackage

// File: rtl/mm_job_scheduler_job_fifo.sv
// Synchronous job FIFO with occupancy count. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module job_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mm_job_scheduler.sv
// Matrix-multiply job scheduler: queues host jobs, runs them one at a time
// on the mm controller with a start/valid four-phase handshake, and reports
// each completion (ok, zero-dimension reject, or watchdog timeout).
module mm_job_scheduler
  import mm_job_scheduler_pkg::*;
#(
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDW   = 4,
  parameter int unsigned TOW   = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [AW-1:0]            job_m_i,
  input  logic [AW-1:0]            job_k_i,
  input  logic [AW-1:0]            job_n_i,
  input  logic [AW-1:0]            job_addra_i,
  input  logic [AW-1:0]            job_addrb_i,
  input  logic [AW-1:0]            job_addrp_i,
  input  logic [IDW-1:0]           job_id_i,
  output logic                     done_valid_o,
  input  logic                     done_ready_i,
  output logic [IDW-1:0]           done_id_o,
  output logic [1:0]               done_err_o,
  output logic                     mm_start_o,
  input  logic                     mm_valid_i,
  output logic [AW-1:0]            mm_m_o,
  output logic [AW-1:0]            mm_k_o,
  output logic [AW-1:0]            mm_n_o,
  output logic [AW-1:0]            mm_base_a_o,
  output logic [AW-1:0]            mm_base_b_o,
  output logic [AW-1:0]            mm_base_p_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   pending_o
);

  localparam int unsigned JOB_W = job_width(AW, IDW);

  sch_state_e          state_q, state_d;
  done_err_e           err_q, err_d;
  logic [TOW-1:0]      wd_q, wd_d, wd_inc;
  logic                ready_q;
  logic                start_q;
  logic                done_valid_q;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                load;
  logic [JOB_W-1:0]    fifo_din;
  logic [JOB_W-1:0]    fifo_dout;
  logic [AW-1:0]       head_m, head_k, head_n;
  logic [AW-1:0]       m_q, k_q, n_q, a_q, b_q, p_q;
  logic [IDW-1:0]      id_q;

  assign job_ready_o = ready_q && !fifo_full;
  assign fifo_push   = job_valid_i && job_ready_o;
  assign fifo_din    = {job_id_i, job_addrp_i, job_addrb_i, job_addra_i,
                        job_n_i, job_k_i, job_m_i};

  job_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (DEPTH)
  ) u_job_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (fifo_din),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .count_o (pending_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_m = fifo_dout[0*AW +: AW];
  assign head_k = fifo_dout[1*AW +: AW];
  assign head_n = fifo_dout[2*AW +: AW];

  // Saturating watchdog increment; wd_inc is the count including this RUN cycle.
  assign wd_inc = (wd_q == '1) ? wd_q : wd_q + 1'b1;

  // Next-state, pop/load strobes, error code and watchdog update.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    wd_d     = wd_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    case (state_q)
      SCH_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          if (head_m == '0 || head_k == '0 || head_n == '0) begin
            err_d   = DONE_ZERO;
            state_d = SCH_REPORT;
          end else begin
            err_d   = DONE_OK;
            state_d = SCH_ISSUE;
          end
        end
      end
      SCH_ISSUE: begin
        wd_d    = '0;
        state_d = SCH_RUN;
      end
      SCH_RUN: begin
        wd_d = wd_inc;
        if (mm_valid_i) begin
          err_d   = DONE_OK;
          state_d = SCH_RELEASE;
        end else if (wd_inc == '1) begin
          err_d   = DONE_TIMEOUT;
          state_d = SCH_RELEASE;
        end
      end
      SCH_RELEASE: begin
        wd_d = '0;
        if (err_q == DONE_TIMEOUT || !mm_valid_i) begin
          state_d = SCH_REPORT;
        end
      end
      SCH_REPORT: begin
        if (done_ready_i) begin
          state_d = SCH_IDLE;
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  // State, error, watchdog and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= SCH_IDLE;
      err_q        <= DONE_OK;
      wd_q         <= '0;
      ready_q      <= 1'b0;
      start_q      <= 1'b0;
      done_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      wd_q         <= wd_d;
      ready_q      <= 1'b1;
      start_q      <= (state_d == SCH_ISSUE) || (state_d == SCH_RUN);
      done_valid_q <= (state_d == SCH_REPORT);
    end
  end

  // Job registers: loaded on pop, held through IDLE so the controller never sees a glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q  <= '0;
      k_q  <= '0;
      n_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      p_q  <= '0;
      id_q <= '0;
    end else if (load) begin
      m_q  <= head_m;
      k_q  <= head_k;
      n_q  <= head_n;
      a_q  <= fifo_dout[3*AW +: AW];
      b_q  <= fifo_dout[4*AW +: AW];
      p_q  <= fifo_dout[5*AW +: AW];
      id_q <= fifo_dout[6*AW +: IDW];
    end
  end

  assign mm_start_o   = start_q;
  assign mm_m_o       = m_q;
  assign mm_k_o       = k_q;
  assign mm_n_o       = n_q;
  assign mm_base_a_o  = a_q;
  assign mm_base_b_o  = b_q;
  assign mm_base_p_o  = p_q;
  assign done_valid_o = done_valid_q;
  assign done_id_o    = id_q;
  assign done_err_o   = err_q;
  assign busy_o       = (state_q != SCH_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Randomized bench for mm_job_scheduler with a reference model: a job is
// rejected if any dimension is zero, otherwise it times out when the
// controller has not answered within 2^TOW-1 cycles of RUN.
module tb_mm_job_scheduler;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDW   = 4;
  localparam int unsigned TOW   = 6;
  localparam int unsigned RUN_MAX = (1 << TOW) - 1;

  typedef struct {
    logic [AW-1:0]  m, k, n, a, b, p;
    logic [IDW-1:0] id;
    int unsigned    lat;
    logic [1:0]     err;
  } job_t;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   job_valid_i;
  logic                   job_ready_o;
  logic [AW-1:0]          job_m_i, job_k_i, job_n_i;
  logic [AW-1:0]          job_addra_i, job_addrb_i, job_addrp_i;
  logic [IDW-1:0]         job_id_i;
  logic                   done_valid_o;
  logic                   done_ready_i;
  logic [IDW-1:0]         done_id_o;
  logic [1:0]             done_err_o;
  logic                   mm_start_o;
  logic                   mm_valid_i;
  logic [AW-1:0]          mm_m_o, mm_k_o, mm_n_o;
  logic [AW-1:0]          mm_base_a_o, mm_base_b_o, mm_base_p_o;
  logic                   busy_o;
  logic [$clog2(DEPTH):0] pending_o;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  job_t        exp_q[$];
  job_t        iss_q[$];
  bit          ctl_en     = 1'b1;
  bit          sink_block = 1'b0;

  mm_job_scheduler #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .IDW   (IDW),
    .TOW   (TOW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .job_valid_i  (job_valid_i),
    .job_ready_o  (job_ready_o),
    .job_m_i      (job_m_i),
    .job_k_i      (job_k_i),
    .job_n_i      (job_n_i),
    .job_addra_i  (job_addra_i),
    .job_addrb_i  (job_addrb_i),
    .job_addrp_i  (job_addrp_i),
    .job_id_i     (job_id_i),
    .done_valid_o (done_valid_o),
    .done_ready_i (done_ready_i),
    .done_id_o    (done_id_o),
    .done_err_o   (done_err_o),
    .mm_start_o   (mm_start_o),
    .mm_valid_i   (mm_valid_i),
    .mm_m_o       (mm_m_o),
    .mm_k_o       (mm_k_o),
    .mm_n_o       (mm_n_o),
    .mm_base_a_o  (mm_base_a_o),
    .mm_base_b_o  (mm_base_b_o),
    .mm_base_p_o  (mm_base_p_o),
    .busy_o       (busy_o),
    .pending_o    (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic job_t mk_job(input int unsigned m, input int unsigned k,
                                  input int unsigned n, input int unsigned id,
                                  input int unsigned lat);
    job_t j;
    j.m   = AW'(m);
    j.k   = AW'(k);
    j.n   = AW'(n);
    j.a   = AW'($urandom);
    j.b   = AW'($urandom);
    j.p   = AW'($urandom);
    j.id  = IDW'(id);
    j.lat = lat;
    j.err = 2'd0;
    return j;
  endfunction

  function automatic job_t rand_job();
    job_t        j;
    int unsigned r;
    int unsigned lat;
    r = $urandom_range(0, 9);
    if (r < 7)       lat = $urandom_range(1, 25);
    else if (r == 7) lat = RUN_MAX;
    else if (r == 8) lat = RUN_MAX + 1;
    else             lat = $urandom_range(RUN_MAX + 2, RUN_MAX + 25);
    j = mk_job($urandom_range(1, 255), $urandom_range(1, 255), $urandom_range(1, 255),
               $urandom_range(0, 15), lat);
    case ($urandom_range(0, 9))
      0: j.m = '0;
      1: j.k = '0;
      2: j.n = '0;
      default: ;
    endcase
    return j;
  endfunction

  // Offer a job at a negedge and hold it until accepted; rec=1 adds it to the model.
  task automatic push_job(input job_t j, input bit rec);
    int unsigned cnt;
    job_m_i     = j.m;
    job_k_i     = j.k;
    job_n_i     = j.n;
    job_addra_i = j.a;
    job_addrb_i = j.b;
    job_addrp_i = j.p;
    job_id_i    = j.id;
    job_valid_i = 1'b1;
    cnt = 0;
    while (!job_ready_o && cnt < 500) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("push_ready", job_ready_o, 1'b1);
    if (rec) begin
      if (j.m == 0 || j.k == 0 || j.n == 0) begin
        j.err = 2'd1;
      end else begin
        j.err = (j.lat <= RUN_MAX) ? 2'd0 : 2'd2;
        iss_q.push_back(j);
      end
      exp_q.push_back(j);
    end
    @(negedge clk_i);
    job_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned cnt;
    cnt = 0;
    while ((busy_o || exp_q.size() != 0) && cnt < 5000) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("drain_busy", busy_o, 1'b0);
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Controller model: answers start after the job's latency, holds valid a little past start.
  initial begin
    job_t        cj;
    int unsigned hi, k, exp_hi, hold;
    mm_valid_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (ctl_en && rst_ni && mm_start_o) begin
        chk("start_has_job", iss_q.size() != 0, 1'b1);
        if (iss_q.size() != 0) begin
          cj = iss_q.pop_front();
          chk("mm_dims", {mm_m_o, mm_k_o, mm_n_o}, {cj.m, cj.k, cj.n});
          chk("mm_base", {mm_base_a_o, mm_base_b_o, mm_base_p_o}, {cj.a, cj.b, cj.p});
          hi = 1;
          k  = 0;
          while (k < 300) begin
            if (k == cj.lat) mm_valid_i = 1'b1;
            @(negedge clk_i);
            k++;
            if (!mm_start_o) break;
            hi++;
          end
          exp_hi = (cj.lat <= RUN_MAX) ? cj.lat + 1 : RUN_MAX + 1;
          chk("start_len", hi, exp_hi);
          chk("mm_dims_hold", {mm_m_o, mm_k_o, mm_n_o}, {cj.m, cj.k, cj.n});
          hold = $urandom_range(0, 3);
          for (int unsigned h = 0; h < hold && mm_valid_i; h++) begin
            chk("no_done_while_valid", done_valid_o, 1'b0);
            @(negedge clk_i);
          end
          mm_valid_i = 1'b0;
        end else begin
          for (int unsigned w = 0; w < 300 && mm_start_o; w++) @(negedge clk_i);
        end
      end
    end
  end

  // Completion sink: random ready, checks records in push order and stability while stalled.
  initial begin
    job_t        e;
    bit          prev_v, prev_hs, hs;
    logic [6:0]  prev_rec;
    done_ready_i = 1'b0;
    prev_v  = 1'b0;
    prev_hs = 1'b1;
    prev_rec = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_v = 1'b0;
        done_ready_i = 1'b0;
        continue;
      end
      if (prev_v && !prev_hs) chk("done_hold", {done_valid_o, done_id_o, done_err_o}, prev_rec);
      done_ready_i = sink_block ? 1'b0 : ($urandom_range(0, 2) != 0);
      hs = done_valid_o && done_ready_i;
      if (hs) begin
        chk("done_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("done_rec", {done_id_o, done_err_o}, {e.id, e.err});
        end
      end
      prev_v   = done_valid_o;
      prev_hs  = hs;
      prev_rec = {done_valid_o, done_id_o, done_err_o};
    end
  end

  initial begin
    job_t        ja, jb;
    int unsigned cnt;
    rst_ni      = 1'b0;
    job_valid_i = 1'b0;
    job_m_i = '0; job_k_i = '0; job_n_i = '0;
    job_addra_i = '0; job_addrb_i = '0; job_addrp_i = '0;
    job_id_i = '0;
    #2;
    chk("rst_outs", {job_ready_o, done_valid_o, mm_start_o, busy_o, pending_o, done_id_o, done_err_o},
        '0);
    chk("rst_mm", {mm_m_o, mm_k_o, mm_n_o, mm_base_a_o, mm_base_b_o, mm_base_p_o}, '0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_rst", job_ready_o, 1'b1);

    // Single job, controller answers 20 cycles after start.
    push_job(mk_job(8, 8, 8, 3, 20), 1'b1);
    wait_idle();

    // Five back-to-back pushes: the first is popped, the next four fill the FIFO.
    push_job(mk_job(5, 6, 7, 1, 30), 1'b1);
    for (int unsigned i = 2; i <= 5; i++) push_job(mk_job(i, i, i, i, 5), 1'b1);
    chk("full_pending", pending_o, DEPTH);
    chk("full_ready", job_ready_o, 1'b0);
    chk("full_busy", busy_o, 1'b1);
    push_job(mk_job(9, 9, 9, 6, 4), 1'b1);
    wait_idle();

    // Zero-dimension reject reported within two cycles without a start.
    push_job(mk_job(4, 0, 4, 7, 3), 1'b1);
    cnt = 0;
    while (!done_valid_o && cnt < 2) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("zero_done_fast", {done_valid_o, done_id_o, done_err_o}, {1'b1, 4'd7, 2'd1});
    wait_idle();

    // Timeout, then a normal job; boundary latencies on both sides of the watchdog.
    push_job(mk_job(3, 3, 3, 9, 1000), 1'b1);
    push_job(mk_job(2, 2, 2, 10, 6), 1'b1);
    push_job(mk_job(2, 2, 2, 11, RUN_MAX), 1'b1);
    push_job(mk_job(2, 2, 2, 12, RUN_MAX + 1), 1'b1);
    wait_idle();

    // Host stalls the done channel: record holds, next job is not issued.
    sink_block = 1'b1;
    ja = mk_job(10, 11, 12, 13, 3);
    jb = mk_job(20, 21, 22, 14, 3);
    push_job(ja, 1'b1);
    push_job(jb, 1'b1);
    cnt = 0;
    while (!done_valid_o && cnt < 100) begin
      @(negedge clk_i);
      cnt++;
    end
    for (int unsigned i = 0; i < 10; i++) begin
      chk("stall_rec", {done_valid_o, done_id_o}, {1'b1, ja.id});
      chk("stall_no_issue", mm_start_o, 1'b0);
      chk("stall_pending", pending_o, 1);
      @(negedge clk_i);
    end
    sink_block = 1'b0;
    wait_idle();

    // Randomized traffic.
    for (int unsigned i = 0; i < 40; i++) begin
      push_job(rand_job(), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk_i);
    end
    wait_idle();

    // Reset while a job is running and others are queued.
    ctl_en = 1'b0;
    for (int unsigned i = 0; i < 3; i++) push_job(mk_job(1, 2, 3, i, 0), 1'b0);
    cnt = 0;
    while (!mm_start_o && cnt < 20) begin
      @(negedge clk_i);
      cnt++;
    end
    repeat (3) @(negedge clk_i);
    chk("run_before_rst", {mm_start_o, pending_o != 0}, 2'b11);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_job", {mm_start_o, done_valid_o, pending_o, busy_o}, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("after_rst_quiet", {mm_start_o, done_valid_o, pending_o, busy_o, job_ready_o}, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running exp=finished");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1);
  end

endmodule
